// File: rtl/video_timing_gen.sv
// Raster timing and pixel-fetch stage ahead of the TMDS encoder.
// Divides the bit clock into pixel periods and walks an (h,v) raster. It
// generates sync, display enable and a per-pixel strobe, and pops one RGB
// pixel from a first-word-fall-through FIFO for each active pixel.
// The FIFO word is sampled at the edge that opens an active period, so the
// captured pixel and the pop strobe are both visible from that period's first
// cycle. Parameters must give H/V totals of at most 4095.
module video_timing_gen #(
    parameter int unsigned CLKS_PER_PIXEL = 10,
    parameter int unsigned H_ACTIVE       = 640,
    parameter int unsigned H_FP           = 16,
    parameter int unsigned H_SYNC         = 96,
    parameter int unsigned H_BP           = 48,
    parameter int unsigned V_ACTIVE       = 480,
    parameter int unsigned V_FP           = 10,
    parameter int unsigned V_SYNC         = 2,
    parameter int unsigned V_BP           = 33,
    parameter int unsigned SYNC_POL       = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [23:0] fifo_data,
    input  logic        fifo_empty,
    output logic        fifo_rd_en,
    output logic [7:0]  red_out,
    output logic [7:0]  green_out,
    output logic [7:0]  blue_out,
    output logic        data_ready,
    output logic        disp_enable,
    output logic        C0,
    output logic        C1,
    output logic [11:0] x_pos,
    output logic [11:0] y_pos,
    output logic        frame_start,
    output logic        underflow
);

    localparam int unsigned CNT_W    = 12;
    localparam int unsigned P_W      = (CLKS_PER_PIXEL > 2) ? $clog2(CLKS_PER_PIXEL) : 1;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;
    localparam logic        SYNC_ON  = (SYNC_POL != 0);
    localparam logic        SYNC_OFF = ~SYNC_ON;

    // running is low in the reset/idle state; the first enabled edge then
    // opens period (0,0) instead of advancing past it.
    logic             running;
    logic [P_W-1:0]   p;
    logic [P_W-1:0]   p_nxt;
    logic [CNT_W-1:0] h_nxt;
    logic [CNT_W-1:0] v_nxt;
    logic             active_nxt;
    logic             pix_start_nxt;
    logic             hsync_nxt;
    logic             vsync_nxt;
    logic             frame_start_nxt;

    // Next raster position; x_pos/y_pos hold the current h/v directly.
    always_comb begin
        p_nxt = '0;
        h_nxt = '0;
        v_nxt = '0;
        if (running) begin
            p_nxt = p + P_W'(1);
            h_nxt = x_pos;
            v_nxt = y_pos;
            if (p == P_W'(CLKS_PER_PIXEL - 1)) begin
                p_nxt = '0;
                if (x_pos == CNT_W'(H_TOTAL - 1)) begin
                    h_nxt = '0;
                    v_nxt = (y_pos == CNT_W'(V_TOTAL - 1)) ? '0 : y_pos + CNT_W'(1);
                end else begin
                    h_nxt = x_pos + CNT_W'(1);
                end
            end
        end
    end

    // Decode of the period being entered.
    always_comb begin
        active_nxt      = (h_nxt < CNT_W'(H_ACTIVE)) && (v_nxt < CNT_W'(V_ACTIVE));
        pix_start_nxt   = active_nxt && (p_nxt == '0);
        hsync_nxt       = ((h_nxt >= CNT_W'(HS_START)) && (h_nxt < CNT_W'(HS_END))) ? SYNC_ON : SYNC_OFF;
        vsync_nxt       = ((v_nxt >= CNT_W'(VS_START)) && (v_nxt < CNT_W'(VS_END))) ? SYNC_ON : SYNC_OFF;
        frame_start_nxt = (p_nxt == '0) && (h_nxt == '0) && (v_nxt == '0);
    end

    // Counter and output registers; enable low idles everything but underflow.
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            running     <= 1'b0;
            p           <= '0;
            x_pos       <= '0;
            y_pos       <= '0;
            fifo_rd_en  <= 1'b0;
            data_ready  <= 1'b0;
            disp_enable <= 1'b0;
            frame_start <= 1'b0;
            C0          <= SYNC_OFF;
            C1          <= SYNC_OFF;
            red_out     <= '0;
            green_out   <= '0;
            blue_out    <= '0;
            if (rst) begin
                underflow <= 1'b0;
            end
        end else begin
            running     <= 1'b1;
            p           <= p_nxt;
            x_pos       <= h_nxt;
            y_pos       <= v_nxt;
            disp_enable <= active_nxt;
            C0          <= hsync_nxt;
            C1          <= vsync_nxt;
            frame_start <= frame_start_nxt;
            data_ready  <= pix_start_nxt;
            fifo_rd_en  <= pix_start_nxt && !fifo_empty;
            if (pix_start_nxt) begin
                if (fifo_empty) begin
                    red_out   <= '0;
                    green_out <= '0;
                    blue_out  <= '0;
                    underflow <= 1'b1;
                end else begin
                    red_out   <= fifo_data[23:16];
                    green_out <= fifo_data[15:8];
                    blue_out  <= fifo_data[7:0];
                end
            end else if (!active_nxt) begin
                red_out   <= '0;
                green_out <= '0;
                blue_out  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen on a tiny 8x5 raster with 10 clocks per pixel.
module tb_video_timing_gen;

    localparam int CPP = 10;
    localparam int HA = 4, HF = 1, HS = 2, HB = 1;
    localparam int VA = 2, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = CPP * HT * VT;
    localparam logic SP = 1'b0;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [23:0] fifo_data;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [7:0]  red_out, green_out, blue_out;
    logic        data_ready, disp_enable, C0, C1, frame_start, underflow;
    logic [11:0] x_pos, y_pos;

    video_timing_gen #(
        .CLKS_PER_PIXEL(CPP), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(0)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .fifo_data(fifo_data), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
        .data_ready(data_ready), .disp_enable(disp_enable), .C0(C0), .C1(C1),
        .x_pos(x_pos), .y_pos(y_pos), .frame_start(frame_start), .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rd;
        logic [23:0] rgb;
        logic        dr;
        logic        de;
        logic        c0;
        logic        c1;
        logic [11:0] x;
        logic [11:0] y;
        logic        fs;
        logic        uf;
    } outs_t;

    typedef struct {
        int          n;
        logic        r;
        logic        en;
        logic        emp;
        logic [23:0] d;
        outs_t       e;
    } vec_t;

    int    checks = 0;
    int    errors = 0;
    int    tcount = 0;
    int    m_cyc  = -1;
    logic  m_uf   = 1'b0;
    outs_t m_out  = '0;
    vec_t  tbl [20];

    function automatic outs_t mk(logic rd, logic [23:0] rgb, logic dr, logic de, logic c0,
                                 logic c1, int x, int y, logic fs, logic uf);
        outs_t o;
        o.rd = rd; o.rgb = rgb; o.dr = dr; o.de = de; o.c0 = c0; o.c1 = c1;
        o.x = 12'(x); o.y = 12'(y); o.fs = fs; o.uf = uf;
        return o;
    endfunction

    function automatic outs_t dut_out();
        return mk(fifo_rd_en, {red_out, green_out, blue_out}, data_ready, disp_enable,
                  C0, C1, int'(x_pos), int'(y_pos), frame_start, underflow);
    endfunction

    function automatic string fmt(outs_t o);
        return $sformatf("rd=%b rgb=%h dr=%b de=%b c0=%b c1=%b x=%0d y=%0d fs=%b uf=%b",
                         o.rd, o.rgb, o.dr, o.de, o.c0, o.c1, o.x, o.y, o.fs, o.uf);
    endfunction

    task automatic check(input string name, input outs_t a, input outs_t e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s act{%s} exp{%s}", name, fmt(a), fmt(e));
        end
    endtask

    task automatic check_int(input string name, input int a, input int e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d", name, a, e);
        end
    endtask

    // Reference: position is pure arithmetic on cycles elapsed since (0,0).
    task automatic model_edge(input logic r, input logic en, input logic emp, input logic [23:0] d);
        int p, pix, h, v;
        logic act;
        if (r || !en) begin
            m_cyc = -1;
            if (r) m_uf = 1'b0;
            m_out = '0;
            m_out.c0 = ~SP;
            m_out.c1 = ~SP;
        end else begin
            m_cyc = (m_cyc < 0) ? 0 : (m_cyc + 1) % FRAME;
            p   = m_cyc % CPP;
            pix = m_cyc / CPP;
            h   = pix % HT;
            v   = pix / HT;
            act = (h < HA) && (v < VA);
            m_out.x  = 12'(h);
            m_out.y  = 12'(v);
            m_out.de = act;
            m_out.c0 = (h >= HA + HF && h < HA + HF + HS) ? SP : ~SP;
            m_out.c1 = (v >= VA + VF && v < VA + VF + VS) ? SP : ~SP;
            m_out.fs = (m_cyc == 0);
            m_out.dr = act && (p == 0);
            m_out.rd = m_out.dr && !emp;
            if (act && p == 0) begin
                m_out.rgb = emp ? 24'h0 : d;
                if (emp) m_uf = 1'b1;
            end else if (!act) begin
                m_out.rgb = 24'h0;
            end
        end
        m_out.uf = m_uf;
    endtask

    task automatic step(input logic r, input logic en, input logic emp, input logic [23:0] d);
        rst = r; enable = en; fifo_empty = emp; fifo_data = d;
        @(posedge clk);
        model_edge(r, en, emp, d);
        @(negedge clk);
        check($sformatf("model_cycle%0d", tcount), dut_out(), m_out);
        tcount++;
    endtask

    initial begin
        int fs_cnt, dr_cnt, rd_cnt, c0_low, c1_low, last_fs, fs_gap_bad;

        rst = 1'b1; enable = 1'b0; fifo_empty = 1'b0; fifo_data = '0;

        // Expected values derived by hand for the 8x5 raster, 10 clocks per pixel.
        tbl[0]  = '{2,   1'b1, 1'b1, 1'b0, 24'h000000, mk(0, 24'h000000, 0, 0, 1, 1, 0, 0, 0, 0)};
        tbl[1]  = '{1,   1'b0, 1'b1, 1'b0, 24'hFF0000, mk(1, 24'hFF0000, 1, 1, 1, 1, 0, 0, 1, 0)};
        tbl[2]  = '{9,   1'b0, 1'b1, 1'b0, 24'h00FF00, mk(0, 24'hFF0000, 0, 1, 1, 1, 0, 0, 0, 0)};
        tbl[3]  = '{1,   1'b0, 1'b1, 1'b0, 24'h00FF00, mk(1, 24'h00FF00, 1, 1, 1, 1, 1, 0, 0, 0)};
        tbl[4]  = '{10,  1'b0, 1'b1, 1'b0, 24'h0000FF, mk(1, 24'h0000FF, 1, 1, 1, 1, 2, 0, 0, 0)};
        tbl[5]  = '{10,  1'b0, 1'b1, 1'b1, 24'h123456, mk(0, 24'h000000, 1, 1, 1, 1, 3, 0, 0, 1)};
        tbl[6]  = '{10,  1'b0, 1'b1, 1'b0, 24'hABCDEF, mk(0, 24'h000000, 0, 0, 1, 1, 4, 0, 0, 1)};
        tbl[7]  = '{10,  1'b0, 1'b1, 1'b0, 24'hABCDEF, mk(0, 24'h000000, 0, 0, 0, 1, 5, 0, 0, 1)};
        tbl[8]  = '{20,  1'b0, 1'b1, 1'b0, 24'hABCDEF, mk(0, 24'h000000, 0, 0, 1, 1, 7, 0, 0, 1)};
        tbl[9]  = '{10,  1'b0, 1'b1, 1'b0, 24'h111111, mk(1, 24'h111111, 1, 1, 1, 1, 0, 1, 0, 1)};
        tbl[10] = '{20,  1'b0, 1'b1, 1'b0, 24'h111111, mk(1, 24'h111111, 1, 1, 1, 1, 2, 1, 0, 1)};
        tbl[11] = '{1,   1'b1, 1'b1, 1'b0, 24'h111111, mk(0, 24'h000000, 0, 0, 1, 1, 0, 0, 0, 0)};
        tbl[12] = '{1,   1'b0, 1'b1, 1'b0, 24'h222222, mk(1, 24'h222222, 1, 1, 1, 1, 0, 0, 1, 0)};
        tbl[13] = '{5,   1'b0, 1'b1, 1'b1, 24'h333333, mk(0, 24'h222222, 0, 1, 1, 1, 0, 0, 0, 0)};
        tbl[14] = '{5,   1'b0, 1'b1, 1'b1, 24'h333333, mk(0, 24'h000000, 1, 1, 1, 1, 1, 0, 0, 1)};
        tbl[15] = '{5,   1'b0, 1'b0, 1'b0, 24'h444444, mk(0, 24'h000000, 0, 0, 1, 1, 0, 0, 0, 1)};
        tbl[16] = '{1,   1'b0, 1'b1, 1'b0, 24'h444444, mk(1, 24'h444444, 1, 1, 1, 1, 0, 0, 1, 1)};
        tbl[17] = '{299, 1'b0, 1'b1, 1'b0, 24'h444444, mk(0, 24'h000000, 0, 0, 0, 0, 5, 3, 0, 1)};
        tbl[18] = '{101, 1'b0, 1'b1, 1'b0, 24'h444444, mk(1, 24'h444444, 1, 1, 1, 1, 0, 0, 1, 1)};
        tbl[19] = '{1,   1'b1, 1'b1, 1'b0, 24'h444444, mk(0, 24'h000000, 0, 0, 1, 1, 0, 0, 0, 0)};

        for (int i = 0; i < 20; i++) begin
            for (int k = 0; k < tbl[i].n; k++) step(tbl[i].r, tbl[i].en, tbl[i].emp, tbl[i].d);
            check($sformatf("vector%0d", i), dut_out(), tbl[i].e);
        end

        // Two full frames with a full FIFO: strobe and sync census.
        step(1'b1, 1'b1, 1'b0, 24'h0);
        fs_cnt = 0; dr_cnt = 0; rd_cnt = 0; c0_low = 0; c1_low = 0;
        last_fs = -1; fs_gap_bad = 0;
        for (int k = 0; k < 2 * FRAME; k++) begin
            step(1'b0, 1'b1, 1'b0, 24'($urandom));
            if (frame_start) begin
                if (last_fs >= 0 && k - last_fs != FRAME) fs_gap_bad++;
                last_fs = k;
                fs_cnt++;
            end
            if (data_ready) dr_cnt++;
            if (fifo_rd_en) rd_cnt++;
            if (C0 == SP) c0_low++;
            if (C1 == SP) c1_low++;
        end
        check_int("frame_start_count", fs_cnt, 2);
        check_int("frame_start_gap", fs_gap_bad, 0);
        check_int("data_ready_count", dr_cnt, 2 * HA * VA);
        check_int("fifo_rd_en_count", rd_cnt, 2 * HA * VA);
        check_int("hsync_cycles", c0_low, 2 * VT * HS * CPP);
        check_int("vsync_cycles", c1_low, 2 * VS * HT * CPP);

        // Random traffic against the reference model.
        for (int k = 0; k < 4000; k++) begin
            step(($urandom_range(0, 599) == 0), ($urandom_range(0, 249) != 0),
                 ($urandom_range(0, 7) == 0), 24'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
